om_frame_scheduler: RTL
=======================

# om_frame_scheduler

Per-frame sequencer and object-map port owner for the board renderer. On each vertical-blank pulse it runs the game-logic step, then arms `entities_drawer` (via `next_screen` then `new_state`) and waits for it to finish. It also time-multiplexes the single-port object-map RAM (100 cells × 11 bits) between the host loader, the game logic and the drawer, so that exactly one requester drives it at a time.

## Interface
- `DRAW_TIMEOUT`, 4096: watchdog limit, in cycles, for the LOGIC and DRAW phases.
- `OM_ADDR_W`, 7: object-map address width.
- `OM_DATA_W`, 11: object-map word width.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `vblank_start` in 1: 1-cycle pulse at the start of vertical blank.
- `logic_start` out 1: 1-cycle pulse that starts the game-logic step.
- `logic_done` in 1: 1-cycle pulse; game logic has finished.
- `logic_we`, `logic_addr`, `logic_wdata` in 1/7/11: game-logic RAM request.
- `next_screen` out 1: pulse to `entities_drawer`.
- `new_state` out 1: pulse to `entities_drawer`.
- `draw_addr` in 7: drawer read address (`address_read_om`).
- `draw_done` in 1: 1-cycle pulse; the drawer has finished its pass.
- `host_req`, `host_we`, `host_addr`, `host_wdata` in 1/1/7/11: level-loader request.
- `host_gnt` out 1: host owns the RAM this cycle.
- `om_addr`, `om_we`, `om_wdata` out 7/1/11: RAM port.
- `phase` out 3: current state encoding.
- `frame_count` out 16: number of completed frames; wraps.
- `overrun_count` out 8: number of ignored vblanks; saturates at 255.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE=0, LOGIC=1, ARM=2, DRAW=3, RECOVER=4. Reset state is IDLE.
- **IDLE.** RAM owner is the host when `host_req`=1, otherwise nobody.
  - `host_gnt` = `host_req`.
  - `vblank_start` with `host_req`=0: pulse `logic_start`, go to LOGIC.
  - `vblank_start` with `host_req`=1: stay in IDLE, increment `overrun_count`. The frame is skipped and the host is not preempted.
- **LOGIC.** Owner is the logic requester.
  - On `logic_done`: pulse `next_screen`, go to ARM.
- **ARM.** Owner is the drawer. Lasts exactly 1 cycle.
  - Pulse `new_state`, go to DRAW.
  - `new_state` must never be asserted in the same cycle as `next_screen`.
- **DRAW.** Owner is the drawer.
  - On `draw_done`: increment `frame_count`, go to IDLE.
- **Watchdog.**
  - A counter clears on entry to LOGIC or DRAW and increments each cycle in those states.
  - Reaching `DRAW_TIMEOUT`-1 sets `timeout_err` and moves to RECOVER.
  - RECOVER drives no owner and returns to IDLE after 1 cycle.
  - `frame_count` is not incremented on a timeout.
- **Overrun.** `vblank_start` in any state other than IDLE increments `overrun_count` (saturating at 255). It is otherwise ignored.
- **Simultaneous events.**
  - `logic_done` together with a watchdog expiry: `logic_done` wins.
  - Same rule for `draw_done`.
  - `vblank_start` together with `draw_done`: counts as an overrun. Return to IDLE as normal.
- **RAM mux.**
  - Non-owner requests are ignored.
  - `om_we` = owner's `we` only for the host and logic owners. It is always 0 for the drawer and for no owner.
  - With no owner: `om_addr`=0, `om_wdata`=0.
- **Read data.** RAM read data goes directly to all requesters and is not registered here. Only the current owner may consume it.

## Timing
- State, pulses, counters and `timeout_err` are registered.
- RAM mux outputs are combinational from the registered state and the requester inputs. They add 0 cycles to the RAM's own 1-cycle read latency.
- `logic_start` is high in the cycle after the `vblank_start` edge is sampled; the state reads LOGIC in that same cycle.
- `next_screen` is high the cycle after `logic_done`. `new_state` follows exactly 1 cycle later.
- The drawer owns the address from the `next_screen` cycle onward.
- Reset values:
  - state IDLE.
  - `logic_start`, `next_screen`, `new_state`, `host_gnt`, `om_we` = 0.
  - `om_addr`, `om_wdata` = 0.
  - `frame_count`, `overrun_count`, watchdog counter = 0.
  - `timeout_err` = 0.
- Reset mid-frame: asynchronous return to IDLE; any in-flight write is dropped because `om_we` goes to 0 immediately.

## Structure
- Package `om_sched_pkg` holds:
  - the state enum;
  - `OM_ADDR_W`=7, `OM_DATA_W`=11, `BOARD_CELLS`=100;
  - the owner enum (NONE, HOST, LOGIC, DRAW).
- Sub-module `om_port_mux`: purely combinational owner → `om_addr`/`om_we`/`om_wdata` select. It is reused by the debug readback path.
- The top level holds the FSM, the watchdog and the counters.

## Test plan
- **Normal frame:** `vblank_start` → `logic_start` 1 cycle later; `logic_done` at cycle 20 → `next_screen` at 21, `new_state` at 22; `draw_done` at 300 → IDLE, `frame_count`=1.
- **Host load:** `host_req`=1, `host_we`=1, `host_addr`=99, `host_wdata`=0x5A3 in IDLE → `host_gnt`=1, `om_addr`=99, `om_we`=1. A `vblank_start` during the load → stay in IDLE, `overrun_count`=1.
- **Write isolation:** in DRAW, drive `logic_we`=1 with `logic_addr`=5 → `om_we`=0 and `om_addr` = `draw_addr`.
- **Watchdog:** `DRAW_TIMEOUT`=64, never pulse `draw_done` → `timeout_err`=1 at DRAW entry+63, RECOVER, then IDLE; `frame_count` unchanged.
- **Overrun saturation:** 300 `vblank_start` pulses while held in LOGIC → `overrun_count`=255.
- **Async reset in ARM:** `rst_n`=0 → `phase`=0, `new_state`=0, `om_we`=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/om_sched_pkg.sv
// Shared types and constants for the frame scheduler and its object-map port mux.
//   state_e  : scheduler phase encoding (also exported on the phase port)
//   owner_e  : which requester currently drives the object-map RAM
//   om_req_t : one requester's RAM request (write enable, address, write data)
package om_sched_pkg;

  localparam int unsigned OM_ADDR_W   = 7;
  localparam int unsigned OM_DATA_W   = 11;
  localparam int unsigned BOARD_CELLS = 100;
  localparam int unsigned PHASE_W     = 3;
  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned OVR_W       = 8;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOGIC   = 3'd1,
    ST_ARM     = 3'd2,
    ST_DRAW    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_HOST  = 2'd1,
    OWN_LOGIC = 2'd2,
    OWN_DRAW  = 2'd3
  } owner_e;

  typedef struct packed {
    logic                 we;
    logic [OM_ADDR_W-1:0] addr;
    logic [OM_DATA_W-1:0] wdata;
  } om_req_t;

  // RAM owner implied by the scheduler phase; the host only owns it in IDLE.
  function automatic owner_e state_owner(state_e st, logic host_req);
    case (st)
      ST_IDLE:         return host_req ? OWN_HOST : OWN_NONE;
      ST_LOGIC:        return OWN_LOGIC;
      ST_ARM, ST_DRAW: return OWN_DRAW;
      default:         return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/om_frame_scheduler_if.sv
// Object-map access bundle: the three requesters (host loader, game logic,
// drawer), the host grant, and the single RAM port.
//   master : requester side (drives requests, sees grant and RAM port)
//   slave  : scheduler side (owns the grant and drives the RAM port)
interface om_frame_scheduler_if;
  import om_sched_pkg::*;

  logic                 host_req;
  logic                 host_we;
  logic [OM_ADDR_W-1:0] host_addr;
  logic [OM_DATA_W-1:0] host_wdata;
  logic                 host_gnt;

  logic                 logic_we;
  logic [OM_ADDR_W-1:0] logic_addr;
  logic [OM_DATA_W-1:0] logic_wdata;

  logic [OM_ADDR_W-1:0] draw_addr;

  logic [OM_ADDR_W-1:0] om_addr;
  logic                 om_we;
  logic [OM_DATA_W-1:0] om_wdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output logic_we, logic_addr, logic_wdata,
    output draw_addr,
    input  host_gnt, om_addr, om_we, om_wdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  logic_we, logic_addr, logic_wdata,
    input  draw_addr,
    output host_gnt, om_addr, om_we, om_wdata
  );
endinterface

// File: rtl/om_port_mux.sv
// Combinational owner -> object-map RAM port select.
//   owner     : current RAM owner
//   host_r    : host loader request
//   logic_r   : game-logic request
//   draw_addr : drawer read address
//   om        : selected RAM port request
module om_port_mux
  import om_sched_pkg::*;
(
  input  owner_e               owner,
  input  om_req_t              host_r,
  input  om_req_t              logic_r,
  input  logic [OM_ADDR_W-1:0] draw_addr,
  output om_req_t              om
);

  // The drawer is read-only, and an unowned port is parked at zero.
  always_comb begin
    om = '0;
    case (owner)
      OWN_HOST:  om = host_r;
      OWN_LOGIC: om = logic_r;
      OWN_DRAW:  om.addr = draw_addr;
      default:   om = '0;
    endcase
  end

endmodule

// File: rtl/om_frame_scheduler.sv
// Per-frame sequencer: vblank -> game logic -> arm drawer -> draw, with a
// watchdog on the LOGIC and DRAW phases, frame/overrun counters, and ownership
// of the single-port object-map RAM.
//   clk, rst_n     : clock, asynchronous active-low reset
//   vblank_start   : frame trigger pulse
//   logic_start    : pulse starting the game-logic step
//   logic_done     : game-logic completion pulse
//   next_screen    : first drawer arm pulse
//   new_state      : second drawer arm pulse, one cycle after next_screen
//   draw_done      : drawer completion pulse
//   phase          : current state encoding
//   frame_count    : completed frames (wraps)
//   overrun_count  : ignored vblanks (saturates)
//   timeout_err    : sticky watchdog flag
//   bus            : requesters, host grant and RAM port
module om_frame_scheduler
  import om_sched_pkg::*;
#(
  parameter int unsigned DRAW_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vblank_start,
  output logic                logic_start,
  input  logic                logic_done,
  output logic                next_screen,
  output logic                new_state,
  input  logic                draw_done,
  output logic [PHASE_W-1:0]  phase,
  output logic [FRAME_W-1:0]  frame_count,
  output logic [OVR_W-1:0]    overrun_count,
  output logic                timeout_err,
  om_frame_scheduler_if.slave bus
);

  localparam int unsigned WDOG_W = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;

  state_e              state;
  logic [WDOG_W-1:0]   wdog;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                wdog_hit;
  logic                overrun;
  owner_e              owner;
  om_req_t             host_r;
  om_req_t             logic_r;
  om_req_t             om_sel;

  assign phase    = state;
  assign wdog_inc = wdog + WDOG_W'(1);
  assign wdog_hit = (wdog_inc == WDOG_W'(DRAW_TIMEOUT - 1));

  // A vblank is dropped whenever a frame is in flight or the host holds the RAM.
  assign overrun = vblank_start && ((state != ST_IDLE) || bus.host_req);

  // Sequencer, watchdog and counters. Completion pulses win over a same-cycle expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wdog          <= '0;
      logic_start   <= 1'b0;
      next_screen   <= 1'b0;
      new_state     <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
      timeout_err   <= 1'b0;
    end else begin
      logic_start <= 1'b0;
      next_screen <= 1'b0;
      new_state   <= 1'b0;

      if (overrun && (overrun_count != '1)) begin
        overrun_count <= overrun_count + OVR_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (vblank_start && !bus.host_req) begin
            state       <= ST_LOGIC;
            logic_start <= 1'b1;
            wdog        <= '0;
          end
        end
        ST_LOGIC: begin
          if (logic_done) begin
            state       <= ST_ARM;
            next_screen <= 1'b1;
          end else if (wdog_hit) begin
            state       <= ST_RECOVER;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog_inc;
          end
        end
        ST_ARM: begin
          state     <= ST_DRAW;
          new_state <= 1'b1;
          wdog      <= '0;
        end
        ST_DRAW: begin
          if (draw_done) begin
            state       <= ST_IDLE;
            frame_count <= frame_count + FRAME_W'(1);
          end else if (wdog_hit) begin
            state       <= ST_RECOVER;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ownership is released while reset is held so an in-flight write drops at once.
  assign owner = rst_n ? state_owner(state, bus.host_req) : OWN_NONE;

  assign host_r  = '{we: bus.host_we,  addr: bus.host_addr,  wdata: bus.host_wdata};
  assign logic_r = '{we: bus.logic_we, addr: bus.logic_addr, wdata: bus.logic_wdata};

  om_port_mux u_port_mux (
    .owner     (owner),
    .host_r    (host_r),
    .logic_r   (logic_r),
    .draw_addr (bus.draw_addr),
    .om        (om_sel)
  );

  assign bus.host_gnt = (owner == OWN_HOST);
  assign bus.om_addr  = om_sel.addr;
  assign bus.om_we    = om_sel.we;
  assign bus.om_wdata = om_sel.wdata;

endmodule
